// File: rtl/nes_pad_responder.sv
// -----------------------------------------------------------------------------
// nes_pad_responder
//
// Device-side end of the two-wire NES joypad link. Emulates a 4021-style
// parallel-in/serial-out controller register: the host raises latch to
// capture the buttons, then clocks out 8 active-low bits on sda_out, LSB
// (button A) first.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   scl_in       host shift clock (idles low)
//   latch_in     host latch; high loads buttons
//   sda_out      registered serial data to host, active-low button bit
//   buttons[7:0] live button levels, 1 = pressed (bit0 = A ... bit7 = Right)
//   xfer_done    one-cycle pulse on the 8th scl rising edge of a frame
//   overrun      sticky: scl rise seen after the frame was exhausted
//   frame_count  completed frames, wraps 255 -> 0
//   busy         high while in LATCH or SHIFT
//
// Contains a private helper, nes_pad_filter, which conditions one host line.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// nes_pad_filter
//
// Synchronizes one asynchronous host line and applies a counter-based level
// filter: a new level is accepted only after FILTER_LEN consecutive
// synchronized samples disagree with the current filtered level.
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   din        raw asynchronous input
//   level      filtered level
//   level_d    filtered level delayed one clk (for edge detection)
// -----------------------------------------------------------------------------
module nes_pad_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic level_d
);

   // A counter of at least one bit keeps FILTER_LEN = 1 legal.
   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   sample;

   assign sample = sync[SYNC_STAGES-1];

   // NOTE: sequential state is always updated with non-blocking assignments so
   // every flop samples the pre-edge value of its neighbours (the synchronizer
   // chain would collapse into a single flop with blocking assignments).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync    <= '0;
         cnt     <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], din};
         level_d <= level;
         if (sample == level) begin
            // Any agreeing sample restarts the run, so short glitches vanish.
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            level <= sample;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

module nes_pad_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int TIMEOUT     = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       latch_in,
   output logic       sda_out,
   input  logic [7:0] buttons,
   output logic       xfer_done,
   output logic       overrun,
   output logic [7:0] frame_count,
   output logic       busy
);

   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LATCH,
      S_SHIFT,
      S_EXHAUST
   } state_t;

   // ---------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------
   logic scl_f, scl_f_d;
   logic latch_f, latch_f_d;
   logic scl_rise, latch_rise, latch_fall;

   nes_pad_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_scl_filter (
      .clk     (clk),
      .rst     (rst),
      .din     (scl_in),
      .level   (scl_f),
      .level_d (scl_f_d)
   );

   nes_pad_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_latch_filter (
      .clk     (clk),
      .rst     (rst),
      .din     (latch_in),
      .level   (latch_f),
      .level_d (latch_f_d)
   );

   assign scl_rise   = scl_f & ~scl_f_d;
   assign latch_rise = latch_f & ~latch_f_d;
   assign latch_fall = ~latch_f & latch_f_d;

   // Buttons are plain levels: two flops for metastability, no filtering.
   logic [7:0] btn_s1, btn_s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
      end else begin
         btn_s1 <= buttons;
         btn_s2 <= btn_s1;
      end
   end

   // ---------------------------------------------------------------------------
   // Protocol state machine
   // ---------------------------------------------------------------------------
   state_t        state, state_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic [3:0]    bit_cnt, bit_cnt_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          overrun_nxt;
   logic [7:0]    frame_nxt;
   logic          done_nxt;
   logic          sda_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         shreg       <= 8'hFF;
         bit_cnt     <= '0;
         timer       <= '0;
         overrun     <= 1'b0;
         frame_count <= '0;
         xfer_done   <= 1'b0;
         sda_out     <= 1'b1;
      end else begin
         state       <= state_nxt;
         shreg       <= shreg_nxt;
         bit_cnt     <= bit_cnt_nxt;
         timer       <= timer_nxt;
         overrun     <= overrun_nxt;
         frame_count <= frame_nxt;
         xfer_done   <= done_nxt;
         sda_out     <= sda_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default before any branch, so
      // a path that forgets an assignment holds the register instead of
      // inferring a latch.
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      timer_nxt   = timer;
      overrun_nxt = overrun;
      frame_nxt   = frame_count;
      done_nxt    = 1'b0;

      if (latch_rise) begin
         // Latch wins over everything, including a coincident scl rise; any
         // partial frame is discarded uncounted.
         state_nxt   = S_LATCH;
         shreg_nxt   = btn_s2;
         bit_cnt_nxt = '0;
         timer_nxt   = '0;
         overrun_nxt = 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               shreg_nxt = 8'hFF;
            end

            S_LATCH: begin
               // Transparent parallel load until the latch falls; on the fall
               // cycle the last loaded value is kept.
               if (latch_fall) begin
                  state_nxt   = S_SHIFT;
                  bit_cnt_nxt = '0;
                  timer_nxt   = '0;
               end else begin
                  shreg_nxt = btn_s2;
               end
            end

            S_SHIFT: begin
               if (scl_rise) begin
                  timer_nxt = '0;
                  shreg_nxt = {1'b0, shreg[7:1]};
                  if (bit_cnt == 4'd7) begin
                     bit_cnt_nxt = 4'd8;
                     done_nxt    = 1'b1;
                     frame_nxt   = frame_count + 8'd1;
                     state_nxt   = S_EXHAUST;
                     shreg_nxt   = '0;
                  end else begin
                     bit_cnt_nxt = bit_cnt + 4'd1;
                  end
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  // Host went quiet for TIMEOUT cycles: abandon the frame.
                  state_nxt = S_IDLE;
                  shreg_nxt = 8'hFF;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end

            S_EXHAUST: begin
               shreg_nxt = '0;
               if (scl_rise) begin
                  overrun_nxt = 1'b1;
               end
            end

            default: begin
               state_nxt = S_IDLE;
               shreg_nxt = 8'hFF;
            end
         endcase
      end

      // The line idles released (high) outside a transaction; otherwise it
      // mirrors the active-low LSB of the register being loaded.
      sda_nxt = (state_nxt == S_IDLE) ? 1'b1 : ~shreg_nxt[0];
   end

   assign busy = (state == S_LATCH) || (state == S_SHIFT);

endmodule

// File: tb/tb_nes_pad_responder.sv
// -----------------------------------------------------------------------------
// tb_nes_pad_responder
//
// Directed bench for nes_pad_responder acting as a host. Each latch pushes the
// 8 expected sda_out bits (active-low buttons, LSB first) onto a scoreboard;
// each host scl pulse pops one and compares it against sda_out sampled just
// before the rise. Status outputs are compared against bench-held constants.
// -----------------------------------------------------------------------------
module tb_nes_pad_responder;

   localparam int HP      = 8;     // host half-period in clk cycles
   localparam int TIMEOUT = 4096;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_in;
   logic       latch_in;
   logic [7:0] buttons;
   logic       sda_out;
   logic       xfer_done;
   logic       overrun;
   logic [7:0] frame_count;
   logic       busy;

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;
   int d0;

   logic exp_q[$];

   nes_pad_responder #(
      .SYNC_STAGES (2),
      .FILTER_LEN  (3),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .scl_in      (scl_in),
      .latch_in    (latch_in),
      .sda_out     (sda_out),
      .buttons     (buttons),
      .xfer_done   (xfer_done),
      .overrun     (overrun),
      .frame_count (frame_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Count every cycle xfer_done is seen high; a stretched pulse counts twice.
   always @(negedge clk) begin
      if (!rst && xfer_done) done_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Latch pulse with the given buttons; pushes the expected serial frame.
   task automatic latch_frame(input logic [7:0] b);
      buttons = b;
      tick(4);
      latch_in = 1'b1;
      tick(HP);
      check("busy_in_latch", busy, 1'b1);
      latch_in = 1'b0;
      tick(HP);
      for (int i = 0; i < 8; i++) exp_q.push_back(~b[i]);
   endtask

   // n host scl pulses, comparing sda_out against the scoreboard before each rise.
   task automatic shift(input int n);
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed sda %0b with no expected bit queued", sda_out);
         end else begin
            check("sda_bit", sda_out, exp_q.pop_front());
         end
         scl_in = 1'b1;
         tick(HP);
         scl_in = 1'b0;
         tick(HP);
      end
   endtask

   initial begin
      rst      = 1'b1;
      scl_in   = 1'b0;
      latch_in = 1'b0;
      buttons  = 8'h00;
      tick(3);

      // Reset values
      check("rst_sda", sda_out, 1'b1);
      check("rst_done", xfer_done, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_frame_count", frame_count, 8'd0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick(4);

      // Basic frame: A + Right -> 0,1,1,1,1,1,1,0
      d0 = done_cnt;
      latch_frame(8'h81);
      shift(8);
      check("basic_done_pulses", done_cnt - d0, 1);
      check("basic_frame_count", frame_count, 8'd1);
      check("basic_busy", busy, 1'b0);
      check("basic_sda_exhaust", sda_out, 1'b1);
      check("basic_overrun", overrun, 1'b0);

      // Overrun: extra pulses after the frame
      for (int i = 0; i < 2; i++) begin
         check("exhaust_sda", sda_out, 1'b1);
         scl_in = 1'b1;
         tick(HP);
         scl_in = 1'b0;
         tick(HP);
      end
      check("overrun_set", overrun, 1'b1);
      check("overrun_frame_count", frame_count, 8'd1);
      check("overrun_done_pulses", done_cnt - d0, 1);

      // Abort: latch (clears overrun), 3 pulses, then relatch with B pressed
      latch_frame(8'h81);
      check("latch_clears_overrun", overrun, 1'b0);
      shift(3);
      exp_q.delete();
      d0 = done_cnt;
      latch_frame(8'h02);
      buttons = 8'hFF;  // must not disturb the frame already latched
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_frame_count", frame_count, 8'd1);
      shift(8);
      check("abort_next_frame_count", frame_count, 8'd2);
      check("abort_next_done", done_cnt - d0, 1);

      // Glitches shorter than the filter must not shift
      latch_frame(8'h01);
      scl_in = 1'b1;
      tick(1);
      scl_in = 1'b0;
      tick(HP);
      check("glitch1_no_shift", sda_out, 1'b0);
      scl_in = 1'b1;
      tick(2);
      scl_in = 1'b0;
      tick(HP);
      check("glitch2_no_shift", sda_out, 1'b0);
      shift(2);

      // Timeout after TIMEOUT cycles with no scl rise
      d0 = done_cnt;
      tick(TIMEOUT - 200);
      check("pre_timeout_busy", busy, 1'b1);
      tick(300);
      check("timeout_busy", busy, 1'b0);
      check("timeout_sda", sda_out, 1'b1);
      check("timeout_frame_count", frame_count, 8'd2);
      check("timeout_no_done", done_cnt - d0, 0);
      exp_q.delete();

      // Asynchronous reset mid-SHIFT
      latch_frame(8'h5A);
      shift(3);
      rst = 1'b1;
      #1;
      check("midrst_sda", sda_out, 1'b1);
      check("midrst_done", xfer_done, 1'b0);
      check("midrst_overrun", overrun, 1'b0);
      check("midrst_frame_count", frame_count, 8'd0);
      check("midrst_busy", busy, 1'b0);
      exp_q.delete();
      tick(2);
      rst = 1'b0;
      tick(4);

      // Wrap: 256 full frames with random buttons
      d0 = done_cnt;
      for (int f = 0; f < 256; f++) begin
         latch_frame(8'($urandom_range(0, 255)));
         shift(8);
      end
      check("wrap_frame_count", frame_count, 8'd0);
      check("wrap_done_pulses", done_cnt - d0, 256);
      check("wrap_sb_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
